// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI byte writer.
// OLED_SPI_CS_GAP_EN adds the S_GAP state (CS held high before WRITE_DONE).
package oled_pkg;

    localparam int OLED_BYTE_W      = 8;
    localparam int OLED_BIT_W       = $clog2(OLED_BYTE_W);
    localparam int OLED_CLK_DIV_DEF = 2;

    localparam logic OLED_DC_CMD  = 1'b0;
    localparam logic OLED_DC_DATA = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_STOP,
`ifdef OLED_SPI_CS_GAP_EN
        S_GAP,
`endif
        S_ACK
    } oled_state_e;

endpackage

// File: rtl/oled_spi_tick.sv
// Half-period counter for the SPI writer.
// Emits a one-cycle tick when the count reaches CLK_DIV-1.
module oled_spi_tick
    import oled_pkg::*;
#(
    parameter int CLK_DIV = OLED_CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && !clr && (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oled_spi_write.sv
// Byte-level 4-wire SPI transmitter for SSD1306-class OLED panels.
// Define OLED_SPI_CS_GAP_EN to hold CS high for CS_GAP cycles before WRITE_DONE.
module oled_spi_write
    import oled_pkg::*;
#(
    parameter int CLK_DIV = OLED_CLK_DIV_DEF,
    parameter int CS_GAP  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WRITE_START,
    input  logic [OLED_BYTE_W-1:0] DATA,
    input  logic                   DC_IN,
    output logic                   WRITE_DONE,
    output logic                   OLED_SCLK,
    output logic                   OLED_SDIN,
    output logic                   OLED_DC,
    output logic                   OLED_CS
);

    oled_state_e            state_q, state_d;
    logic [OLED_BYTE_W-1:0] sreg_q, sreg_d;
    logic [OLED_BIT_W-1:0]  bit_q, bit_d;
    logic                   sclk_q, sclk_d;
    logic                   sdin_q, sdin_d;
    logic                   dc_q, dc_d;
    logic                   cs_q, cs_d;
    logic                   done_q, done_d;
    logic                   tick;
    logic                   phase_en;

`ifdef OLED_SPI_CS_GAP_EN
    localparam int GAP_W = $clog2(CS_GAP + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`else
    logic unused_cs_gap;
    assign unused_cs_gap = (CS_GAP != 0);
`endif

    assign phase_en = (state_q == S_SHIFT_LO) ||
                      (state_q == S_SHIFT_HI) ||
                      (state_q == S_STOP);

    oled_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (CLK),
        .rst  (RST),
        .clr  (!phase_en),
        .en   (phase_en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        sdin_d  = sdin_q;
        dc_d    = dc_q;
        cs_d    = cs_q;
        done_d  = 1'b0;
`ifdef OLED_SPI_CS_GAP_EN
        gap_d   = gap_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (WRITE_START) begin
                    sreg_d  = DATA;
                    dc_d    = DC_IN;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    sdin_d  = DATA[OLED_BYTE_W-1];
                    bit_d   = OLED_BIT_W'(OLED_BYTE_W - 1);
                    state_d = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    // next bit changes on the same edge SCLK falls
                    if (bit_q != '0) begin
                        bit_d   = bit_q - OLED_BIT_W'(1);
                        sreg_d  = {sreg_q[OLED_BYTE_W-2:0], 1'b0};
                        sdin_d  = sreg_q[OLED_BYTE_W-2];
                        state_d = S_SHIFT_LO;
                    end else begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    cs_d   = 1'b1;
                    sdin_d = 1'b0;
`ifdef OLED_SPI_CS_GAP_EN
                    gap_d   = '0;
                    state_d = S_GAP;
`else
                    done_d  = 1'b1;
                    state_d = S_ACK;
`endif
                end
            end
`ifdef OLED_SPI_CS_GAP_EN
            S_GAP: begin
                if (gap_q == GAP_W'(CS_GAP - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_ACK;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
`endif
            S_ACK: begin
                if (!WRITE_START) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            sdin_q  <= 1'b0;
            dc_q    <= 1'b0;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef OLED_SPI_CS_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            sdin_q  <= sdin_d;
            dc_q    <= dc_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
`ifdef OLED_SPI_CS_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign WRITE_DONE = done_q;
    assign OLED_SCLK  = sclk_q;
    assign OLED_SDIN  = sdin_q;
    assign OLED_DC    = dc_q;
    assign OLED_CS    = cs_q;

endmodule

// File: tb/tb_oled_spi_write.sv
// Bench for oled_spi_write: scoreboarded bytes at CLK_DIV=2,
// plus a CLK_DIV=1 instance for timing of SCLK, CS gap and DONE.
module tb_oled_spi_write;
    import oled_pkg::*;

`ifdef OLED_SPI_CS_GAP_EN
    localparam int GAP = 4;
`else
    localparam int GAP = 0;
`endif
    localparam int LAT0 = 34 + GAP;
    localparam int LAT1 = 17 + GAP;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, dc_in, done, sclk, sdin, dc, cs;
    logic [7:0] data;
    logic       start1, dc_in1, done1, sclk1, sdin1, dc1, cs1;
    logic [7:0] data1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    oled_spi_write #(.CLK_DIV(2), .CS_GAP(4)) u_dut0 (
        .CLK(clk), .RST(rst), .WRITE_START(start),
        .DATA(data), .DC_IN(dc_in), .WRITE_DONE(done),
        .OLED_SCLK(sclk), .OLED_SDIN(sdin),
        .OLED_DC(dc), .OLED_CS(cs)
    );

    oled_spi_write #(.CLK_DIV(1), .CS_GAP(4)) u_dut1 (
        .CLK(clk), .RST(rst), .WRITE_START(start1),
        .DATA(data1), .DC_IN(dc_in1), .WRITE_DONE(done1),
        .OLED_SCLK(sclk1), .OLED_SDIN(sdin1),
        .OLED_DC(dc1), .OLED_CS(cs1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [8:0] sb[$];
    int         pushed = 0;
    int         bytes_done = 0;
    int         bits_seen = 0;
    int         acc_cyc = 0;
    logic [7:0] shreg = '0;
    logic       sclk_p = 1'b0, cs_p = 1'b1, done_p = 1'b0;
    logic [8:0] exp_b;

    always @(negedge clk) begin
        if (rst) begin
            bits_seen = 0;
            sclk_p = 1'b0;
            cs_p = 1'b1;
            done_p = 1'b0;
        end else begin
            if (cs_p && !cs) begin
                acc_cyc = cyc;
                bits_seen = 0;
                shreg = '0;
            end
            if (!sclk_p && sclk) begin
                shreg = {shreg[6:0], sdin};
                bits_seen++;
                check("cs_low_on_rise", cs, 1'b0);
                if (sb.size() != 0)
                    check("dc_during_cs", dc, sb[0][8]);
            end
            if (done_p)
                check("done_width", done, 1'b0);
            if (done && !done_p) begin
                bytes_done++;
                check("byte_expected", bytes_done, pushed);
                check("latency", cyc - acc_cyc, LAT0);
                check("bit_count", bits_seen, 8);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    check("byte_value", shreg, exp_b[7:0]);
                end
            end
            sclk_p = sclk;
            cs_p = cs;
            done_p = done;
        end
    end

    task automatic send(input logic [7:0] d, input logic dcv,
                        input int corrupt_at, input int hold);
        int t;
        sb.push_back({dcv, d});
        pushed++;
        start = 1'b1;
        data = d;
        dc_in = dcv;
        t = 0;
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
            if (corrupt_at >= 0 && !cs && bits_seen > corrupt_at) begin
                data = 8'hFF;
                dc_in = ~dcv;
            end
        end
        check("done_in_time", (t < 300), 1'b1);
        repeat (hold) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    int a1, r1, r2, csr, t1, d0;
    logic ps1, pc1;

    initial begin
        rst = 1'b1;
        start = 1'b0; data = '0; dc_in = 1'b0;
        start1 = 1'b0; data1 = '0; dc_in1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_sdin", sdin, 1'b0);
        check("rst_dc", dc, 1'b0);
        check("rst_done", done, 1'b0);

        rst = 1'b0;
        send(8'hAE, OLED_DC_CMD, -1, 0);
        send(8'h00, OLED_DC_CMD, -1, 0);
        send(8'h10, OLED_DC_CMD, -1, 40);
        check("no_dup_in_ack", bytes_done, 3);

        send(8'h5A, OLED_DC_DATA, -1, 0);
        check("dc_hold_idle", dc, 1'b1);
        send(8'h3C, OLED_DC_CMD, -1, 0);
        check("dc_switched", dc, 1'b0);

        send(8'hA5, OLED_DC_CMD, 3, 0);

        // partial byte killed by reset
        start = 1'b1; data = 8'hC3; dc_in = 1'b1;
        t1 = 0;
        while (!(bits_seen >= 5 && !cs) && t1 < 300) begin
            @(negedge clk);
            t1++;
        end
        check("mid_reach", (t1 < 300), 1'b1);
        d0 = bytes_done;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_cs", cs, 1'b1);
        check("mid_rst_sclk", sclk, 1'b0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("no_done_after_rst", bytes_done, d0);
        send(8'hE7, OLED_DC_DATA, -1, 0);

        // CLK_DIV=1 instance
        start1 = 1'b1; data1 = 8'h96; dc_in1 = 1'b1;
        a1 = -1000; r1 = -1; r2 = -1; csr = -1000; t1 = 0;
        ps1 = 1'b0; pc1 = 1'b1;
        while (!done1 && t1 < 200) begin
            @(negedge clk);
            t1++;
            if (pc1 && !cs1) a1 = cyc;
            if (!pc1 && cs1) csr = cyc;
            if (!ps1 && sclk1) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            ps1 = sclk1;
            pc1 = cs1;
        end
        start1 = 1'b0;
        check("div1_latency", cyc - a1, LAT1);
        check("div1_sclk_period", r2 - r1, 2);
        check("div1_cs_gap", cyc - csr, GAP);
        check("div1_dc", dc1, 1'b1);
        @(negedge clk);
        check("div1_done_width", done1, 1'b0);

        repeat (5) @(negedge clk);
        check("total_bytes", bytes_done, pushed);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
